clk_div_switch: RTL
===================

CLK_DIV_SWITCH -- requirements
Module: clk_div_switch

Interface
REQ-001 SHALL have parameter N_SEL, default 4, number of selectable divisors (2..16).
REQ-002 SHALL have parameter DIV_W, default 8, width of each divisor entry.
REQ-003 SHALL have localparam SEL_W = clog2(N_SEL), minimum 1.
REQ-004 clk  input  1  single clock; all logic on posedge clk.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 sel  input  SEL_W  requested divisor index; values >= N_SEL treated as N_SEL-1.
REQ-007 div_tbl  input  N_SEL*DIV_W  divisor table; entry k = bits [k*DIV_W +: DIV_W]; quasi-static.
REQ-008 clk_stop  input  1  request to park clk_out low (see Configuration).
REQ-009 clk_out  output  1  registered divided clock.
REQ-010 clk_rise  output  1  one-cycle pulse in the first clk cycle clk_out is high (clock-enable use).
REQ-011 cur_sel  output  SEL_W  index currently driving clk_out.
REQ-012 busy  output  1  high while requested index differs from cur_sel or stop/resume is pending.
REQ-013 sw_done  output  1  one-cycle pulse in the cycle a new cur_sel takes effect.

Function
REQ-014 Effective divisor D = table entry of cur_sel; D < 2 SHALL be treated as 2.
REQ-015 Counter cnt SHALL run 0..D-1 then wrap to 0; clk_out high for cnt < floor(D/2), low otherwise (odd D: low phase one cycle longer).
REQ-016 clk_out SHALL be a flop output; no combinational path from clk, sel or div_tbl to clk_out.
REQ-017 States: START, RUN, STOP (STOP only with macro).
REQ-018 START: first edge with rst=0 loads cur_sel=sel, cnt=0, clk_out=1, clk_rise=1, goes to RUN; no sw_done.
REQ-019 Phase boundary = RUN cycle with cnt==D-1; sel SHALL be sampled only at the boundary.
REQ-020 At boundary with sel != cur_sel: cur_sel<=sel, D reloaded from new entry, cnt<=0, clk_out<=1, sw_done=1 next cycle together with clk_rise.
REQ-021 sel changes between boundaries SHALL have no effect except busy; last value at boundary wins; returning to cur_sel before boundary produces no sw_done.
REQ-022 busy SHALL be registered: (sel != cur_sel) evaluated each cycle, cleared in the cycle sw_done asserts.
REQ-023 Result: every clk_out high and low pulse has length of the divisor in force at its start; no runt pulse on any switch.
REQ-024 div_tbl change for cur_sel SHALL take effect only at the next boundary (D latched at cnt wrap).

Reset
REQ-025 rst=1 at any edge, including mid-phase or mid-switch, SHALL give next cycle: clk_out=0, clk_rise=0, cnt=0, cur_sel=0, busy=0, sw_done=0, state START.
REQ-026 Pending switch or stop requests SHALL be discarded by reset.

Configuration
REQ-027 Macro CLK_DIV_SWITCH_STOP_EN: when defined, clk_stop=1 sampled at boundary enters STOP: clk_out held 0, cnt held 0, no clk_rise.
REQ-028 With macro, clk_stop=0 in STOP SHALL resume next edge like START (cur_sel<=sel, clk_out=1, clk_rise=1; sw_done only if index changed); busy high while clk_stop differs from stopped status.
REQ-029 Without macro, clk_stop SHALL be ignored, STOP state absent, busy depends on sel only.

Verification (N_SEL=4, DIV_W=8, div_tbl entries {2,3,4,10})
REQ-030 Reset release, sel=0 -> clk_out 1,0,1,0...; clk_rise every 2nd cycle; cur_sel=0.
REQ-031 sel=1 static -> clk_out pattern high 1, low 2, period 3.
REQ-032 cur_sel=3, sel->0 at cnt==2 -> busy=1, clk_out completes 5 high + 5 low, then sw_done+clk_rise, period 2.
REQ-033 cur_sel=2, sel 2->1->2 within one period -> no sw_done, busy pulses then clears, period stays 4.
REQ-034 rst=1 during high phase of D=10 -> next cycle clk_out=0, cur_sel=0; after release first rise on first edge.
REQ-035 Macro defined, clk_stop=1 mid-high with D=4 -> finishes 2 high + 2 low, holds 0; clk_stop=0 -> clk_rise next edge; without macro period 4 continues uninterrupted.

Source files
------------

// File: rtl/clk_div_switch.sv
// Glitch-free divided clock with a runtime-selectable divisor table.
// Define CLK_DIV_SWITCH_STOP_EN to enable parking clk_out low via clk_stop.
module clk_div_switch #(
    parameter int N_SEL = 4,
    parameter int DIV_W = 8,
    localparam int SEL_W = (N_SEL <= 2) ? 1 : $clog2(N_SEL)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [SEL_W-1:0]       sel,
    input  logic [N_SEL*DIV_W-1:0] div_tbl,
    input  logic                   clk_stop,
    output logic                   clk_out,
    output logic                   clk_rise,
    output logic [SEL_W-1:0]       cur_sel,
    output logic                   busy,
    output logic                   sw_done
);

`ifdef CLK_DIV_SWITCH_STOP_EN
    typedef enum logic [1:0] {START, RUN, STOP} state_t;
`else
    typedef enum logic {START, RUN} state_t;
`endif

    state_t           state_q;
    logic [DIV_W-1:0] d_q;
    logic [DIV_W-1:0] cnt_q;
    logic [SEL_W-1:0] cur_q;
    logic             clk_out_q;
    logic             rise_q;
    logic             busy_q;
    logic             done_q;

    logic [SEL_W-1:0] sel_c;
    logic [DIV_W-1:0] tbl_raw;
    logic [DIV_W-1:0] tbl_d;
    logic [DIV_W-1:0] cnt_inc;
    logic [DIV_W-1:0] half;
    logic             bnd;
    logic             park;
    logic             resume;
    logic             stop_nxt;
    logic             load;
    logic [SEL_W-1:0] cur_nxt;
    logic             busy_d;

    assign sel_c   = (int'(sel) >= N_SEL) ? SEL_W'(N_SEL - 1) : sel;
    assign tbl_raw = div_tbl[int'(sel_c)*DIV_W +: DIV_W];
    assign tbl_d   = (tbl_raw < DIV_W'(2)) ? DIV_W'(2) : tbl_raw;
    assign cnt_inc = cnt_q + DIV_W'(1);
    assign half    = d_q >> 1;
    assign bnd     = (state_q == RUN) && (cnt_q == d_q - DIV_W'(1));

`ifdef CLK_DIV_SWITCH_STOP_EN
    assign park     = bnd && clk_stop;
    assign resume   = (state_q == STOP) && !clk_stop;
    assign stop_nxt = park || ((state_q == STOP) && clk_stop);
`else
    logic unused_stop;
    assign unused_stop = clk_stop;
    assign park        = 1'b0;
    assign resume      = 1'b0;
    assign stop_nxt    = 1'b0;
`endif

    // A new phase always starts high, so switching only at a wrap avoids runts.
    assign load    = (state_q == START) || (bnd && !park) || resume;
    assign cur_nxt = load ? sel_c : cur_q;

`ifdef CLK_DIV_SWITCH_STOP_EN
    assign busy_d = (sel_c != cur_nxt) || (clk_stop != stop_nxt);
`else
    assign busy_d = (sel_c != cur_nxt);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= START;
            d_q       <= DIV_W'(2);
            cnt_q     <= '0;
            cur_q     <= '0;
            clk_out_q <= 1'b0;
            rise_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            busy_q <= busy_d;
            rise_q <= 1'b0;
            done_q <= 1'b0;
            if (load) begin
                done_q    <= (state_q != START) && (sel_c != cur_q);
                state_q   <= RUN;
                cur_q     <= sel_c;
                d_q       <= tbl_d;
                cnt_q     <= '0;
                clk_out_q <= 1'b1;
                rise_q    <= 1'b1;
`ifdef CLK_DIV_SWITCH_STOP_EN
            end else if (park) begin
                state_q   <= STOP;
                cnt_q     <= '0;
                clk_out_q <= 1'b0;
`endif
            end else if (state_q == RUN) begin
                cnt_q     <= cnt_inc;
                clk_out_q <= (cnt_inc < half);
            end
        end
    end

    assign clk_out  = clk_out_q;
    assign clk_rise = rise_q;
    assign cur_sel  = cur_q;
    assign busy     = busy_q;
    assign sw_done  = done_q;

endmodule
